// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only master.
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP
  } state_t;

  localparam int   QTR_DEF = 25;
  localparam logic RW_W    = 1'b0;
endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit timebase: ticks on the last clk of each quarter and tracks the quarter index.
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int QTR = QTR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  output logic       o_tick,
  output logic [1:0] o_q
);
  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_q;
  logic          w_last;

  assign w_last = (r_cnt == CW'(QTR - 1));
  assign o_tick = !i_clr && w_last;
  assign o_q    = r_q;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
      r_q   <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/i2c_master_write_ctrl.sv
// I2C write-only master: START, address+W, data bytes from a valid/ready stream, STOP.
module i2c_master_write_ctrl
  import i2c_pkg::*;
#(
  parameter int QTR = QTR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       wlast,
  input  logic       wvalid,
  output logic       wready,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_in
);
  state_t     r_state, w_next;
  logic [7:0] r_shreg;
  logic [2:0] r_bitcnt;
  logic       r_nack, r_ackbit, r_last, r_done;
  logic       w_tick, w_clr, w_bit_end;
  logic [1:0] w_q;
  logic       w_scl, w_sda_oe, w_wready;

  // Timebase is frozen while idle and while stretching SCL in LOAD,
  // so every bit phase starts from a clean Q0.
  assign w_clr     = (r_state == IDLE) || (r_state == LOAD);
  assign w_bit_end = w_tick && (w_q == 2'd3);

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .o_tick (w_tick),
    .o_q    (w_q)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    w_wready = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = START;
      START: begin
        w_scl    = ~w_q[1];
        w_sda_oe = 1'b1;
        if (w_bit_end) w_next = ADDR;
      end
      ADDR, DATA: begin
        w_scl    = w_q[1];
        w_sda_oe = ~r_shreg[r_bitcnt];
        if (w_bit_end && r_bitcnt == 3'd0)
          w_next = (r_state == ADDR) ? ADDR_ACK : DATA_ACK;
      end
      ADDR_ACK, DATA_ACK: begin
        w_scl = w_q[1];
        if (w_bit_end) begin
          if (r_ackbit)                          w_next = STOP;
          else if (r_state == ADDR_ACK || !r_last) w_next = LOAD;
          else                                   w_next = STOP;
        end
      end
      LOAD: begin
        w_scl    = 1'b0;
        w_wready = 1'b1;
        if (wvalid) w_next = DATA;
      end
      STOP: begin
        // Q0: SCL low with SDA held low; Q1: SCL high; Q2/Q3: SDA released.
        w_scl    = (w_q != 2'd0);
        w_sda_oe = ~w_q[1];
        if (w_bit_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_nack   <= 1'b0;
      r_ackbit <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && w_bit_end;
      case (r_state)
        IDLE: if (start) begin
          r_shreg  <= {addr, RW_W};
          r_bitcnt <= 3'd7;
          r_nack   <= 1'b0;
        end
        ADDR, DATA: if (w_bit_end && r_bitcnt != 3'd0) r_bitcnt <= r_bitcnt - 3'd1;
        ADDR_ACK, DATA_ACK: begin
          if (w_tick && w_q == 2'd2) r_ackbit <= sda_in;
          if (w_bit_end && r_ackbit) r_nack   <= 1'b1;
        end
        LOAD: if (wvalid) begin
          r_shreg  <= wdata;
          r_last   <= wlast;
          r_bitcnt <= 3'd7;
        end
        default: ;
      endcase
    end
  end

  assign scl    = w_scl;
  assign sda_oe = w_sda_oe;
  assign wready = w_wready;
  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign nack   = r_nack;
endmodule

// File: tb/tb_i2c_master_write_ctrl.sv
// Bench for i2c_master_write_ctrl: bus monitor plus ACK/NACK slave, table of write transactions.
module tb_i2c_master_write_ctrl;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       wlast = 1'b0, wvalid = 1'b0;
  logic       wready, busy, done, nack, scl, sda_oe, sda_in;

  always #5 clk = ~clk;

  i2c_master_write_ctrl #(.QTR(4)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .busy(busy), .done(done),
    .nack(nack), .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  int tests = 0, fails = 0;

  // Open-drain line with a slave that pulls low in ACK slots except the one it NACKs.
  logic pull = 1'b0;
  wire  line = !(sda_oe || pull);
  assign sda_in = line;

  int          cur_nack_slot = 0;
  logic        mon_clr = 1'b0;
  logic [63:0] mon_bits = '0;
  int          mon_n = 0, mon_starts = 0, mon_stops = 0;
  logic        mon_have = 1'b0, mon_samp = 1'b0, pscl = 1'b1, pline = 1'b1;

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_bits = '0; mon_n = 0; mon_starts = 0; mon_stops = 0;
      mon_have = 1'b0; pull = 1'b0;
    end else begin
      if (pscl && scl && pline && !line) begin mon_starts++; mon_have = 1'b0; end
      if (pscl && scl && !pline && line) begin mon_stops++;  mon_have = 1'b0; end
      if (!pscl && scl) begin mon_samp = line; mon_have = 1'b1; end
      if (pscl && !scl) begin
        if (mon_have) begin
          mon_bits = {mon_bits[62:0], mon_samp};
          mon_n++;
          mon_have = 1'b0;
        end
        pull = (mon_n % 9 == 8) && (cur_nack_slot != mon_n / 9 + 1);
      end
    end
    pscl  = scl;
    pline = line;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]      addr;
    int              n;
    logic [3:0][7:0] b;          // b[0] sent first
    int              nack_slot;  // 0 none, 1 address, k+1 data byte k
    int              stall;
    bit              extra;      // pulse start again mid-transaction
    int              exp_nbits;
    logic [63:0]     exp_bits;
    logic            exp_nack;
    int              exp_acc;
  } vec_t;

  vec_t vt[7];

  task automatic run(input int v);
    int   ptr = 0, acc = 0, dones = 0, stall_left, stall_bad = 0, post_busy = 0;
    bit   pend = 0, fin = 0;
    string tag;
    tag = $sformatf("v%0d", v);
    stall_left    = vt[v].stall;
    cur_nack_slot = vt[v].nack_slot;
    mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
    addr  = vt[v].addr;
    start = 1'b1;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge clk);
      start = vt[v].extra && (cyc == 60);
      if (pend) begin ptr++; pend = 0; end
      if (ptr < 4) wdata = vt[v].b[ptr];
      wlast = (ptr == vt[v].n - 1);
      if (wready && stall_left > 0) begin
        stall_left--;
        wvalid = 1'b0;
        if (scl !== 1'b0) stall_bad++;
      end else wvalid = 1'b1;
      if (wready && wvalid) begin acc++; pend = 1; end
      if (done) begin
        dones++;
        fin = 1;
        chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
        chk({tag, " nack"}, 64'(nack), 64'(vt[v].exp_nack));
      end
    end
    start = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    if (!fin) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within 5000 cycles", tag);
    end
    repeat (40) @(negedge clk) begin
      if (done) dones++;
      if (busy) post_busy++;
    end
    chk({tag, " nbits"}, 64'(mon_n), 64'(vt[v].exp_nbits));
    chk({tag, " bits"}, mon_bits, vt[v].exp_bits);
    chk({tag, " accepted"}, 64'(acc), 64'(vt[v].exp_acc));
    chk({tag, " done_pulses"}, 64'(dones), 64'(1));
    chk({tag, " start_conds"}, 64'(mon_starts), 64'(1));
    chk({tag, " stop_conds"}, 64'(mon_stops), 64'(1));
    chk({tag, " busy_after"}, 64'(post_busy), 64'(0));
    if (vt[v].stall > 0) begin
      chk({tag, " stall_cycles_left"}, 64'(stall_left), 64'(0));
      chk({tag, " scl_low_in_stall"}, 64'(stall_bad), 64'(0));
    end
  endtask

  initial begin
    vt[0] = '{7'h50, 2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 0, 0, 1'b0, 27,
              64'({8'hA0, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0}), 1'b0, 2};
    vt[1] = '{7'h50, 2, {8'h00, 8'h00, 8'h3C, 8'hA5}, 1, 0, 1'b0, 9,
              64'({8'hA0, 1'b1}), 1'b1, 0};
    vt[2] = '{7'h3B, 3, {8'h00, 8'h33, 8'h22, 8'h11}, 3, 0, 1'b0, 27,
              64'({8'h76, 1'b0, 8'h11, 1'b0, 8'h22, 1'b1}), 1'b1, 2};
    vt[3] = '{7'h7F, 1, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1'b0, 18,
              64'({8'hFE, 1'b0, 8'h00, 1'b0}), 1'b0, 1};
    vt[4] = '{7'h00, 1, {8'h00, 8'h00, 8'h00, 8'hFF}, 0, 0, 1'b0, 18,
              64'({8'h00, 1'b0, 8'hFF, 1'b0}), 1'b0, 1};
    vt[5] = '{7'h12, 1, {8'h00, 8'h00, 8'h00, 8'h5A}, 0, 100, 1'b0, 18,
              64'({8'h24, 1'b0, 8'h5A, 1'b0}), 1'b0, 1};
    vt[6] = '{7'h50, 1, {8'h00, 8'h00, 8'h00, 8'hC3}, 0, 0, 1'b1, 18,
              64'({8'hA0, 1'b0, 8'hC3, 1'b0}), 1'b0, 1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst scl", 64'(scl), 64'(1));
    chk("rst sda_oe", 64'(sda_oe), 64'(0));
    chk("rst wready", 64'(wready), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst nack", 64'(nack), 64'(0));

    for (int v = 0; v < 7; v++) run(v);

    // Reset while the fifth address bit is on the bus.
    begin
      int k;
      cur_nack_slot = 0;
      mon_clr = 1'b1;
      repeat (2) @(negedge clk);
      mon_clr = 1'b0;
      addr  = 7'h50;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (k = 0; k < 2000 && mon_n < 4; k++) @(negedge clk);
      chk("midrst reached_bit4", 64'(mon_n), 64'(4));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst scl", 64'(scl), 64'(1));
      chk("midrst sda_oe", 64'(sda_oe), 64'(0));
      chk("midrst busy", 64'(busy), 64'(0));
      reset = 1'b0;
      repeat (3) @(negedge clk);
    end
    run(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
